// File: rtl/ibus_mem_responder_pkg.sv
// rtl/ibus_mem_responder_pkg.sv - shared constants for the instruction-bus responder
package ibus_mem_responder_pkg;

  localparam int          IBUS_ADDR_W = 32;
  localparam int          IBUS_DATA_W = 32;
  localparam int          LATENCY_MAX = 4;
  localparam int          OUTST_MAX   = 4;
  localparam logic [31:0] NOP_INST    = 32'h00000013;

endpackage

// File: rtl/ibus_rsp_fifo.sv
// rtl/ibus_rsp_fifo.sv - first-word fall-through response FIFO (any depth >= 1)
module ibus_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the head slot in the same edge, so push-while-full is legal then.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/ibus_mem_responder.sv
// rtl/ibus_mem_responder.sv - fetch-side instruction memory responder with loader port
// Define IBUS_ALIGN_CHK_EN to answer misaligned fetches with a NOP error response.
module ibus_mem_responder
  import ibus_mem_responder_pkg::*;
#(
  parameter int ADDR_W    = IBUS_ADDR_W,
  parameter int DATA_W    = IBUS_DATA_W,
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 2,
  parameter int OUTST     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  input  logic              ld_wr_en_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(OUTST_MAX + 1);
  localparam int ENT_W = DATA_W + 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_fire, rsp_fire;
  logic [ADDR_W-3:0] req_word, ld_word;
  logic [IDX_W-1:0]  req_idx, ld_idx;
  logic              req_err, range_err, ld_ok;
  logic [DATA_W-1:0] rd_word;
  logic [ENT_W-1:0]  in_ent, push_ent, fifo_dout;
  logic              push_vld, fifo_empty, fifo_full;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic              unused_ok;

  // Credits come only from the registered count, so ready never depends on rsp_ready_i.
  assign req_ready_o = rst_n & (cnt_q < CNT_W'(OUTST));
  assign req_fire    = req_valid_i & req_ready_o;
  assign rsp_valid_o = ~fifo_empty;
  assign rsp_fire    = rsp_valid_o & rsp_ready_i;

  assign req_word  = req_addr_i[ADDR_W-1:2];
  assign req_idx   = req_addr_i[IDX_W+1:2];
  assign range_err = (req_word >= (ADDR_W-2)'(MEM_DEPTH));
`ifdef IBUS_ALIGN_CHK_EN
  assign req_err   = range_err | (req_addr_i[1:0] != 2'b00);
`else
  assign req_err   = range_err;
`endif

  assign ld_word = ld_addr_i[ADDR_W-1:2];
  assign ld_idx  = ld_addr_i[IDX_W+1:2];
  assign ld_ok   = (ld_word < (ADDR_W-2)'(MEM_DEPTH));

  assign rd_word   = mem_q[req_idx];
  assign in_ent    = {req_err, req_err ? DATA_W'(NOP_INST) : rd_word};
  assign unused_ok = ^{req_addr_i[1:0], ld_addr_i[1:0], fifo_full};

  // Read data is sampled before the loader write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (ld_wr_en_i && ld_ok) mem_q[ld_idx] <= ld_data_i;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (req_fire && !rsp_fire)      cnt_d = cnt_q + CNT_W'(1);
    else if (!req_fire && rsp_fire) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // The FIFO write is the last register of the access path, so LATENCY regs precede it.
  generate
    if (LATENCY == 0) begin : g_nodly
      assign push_vld = req_fire;
      assign push_ent = in_ent;
    end else begin : g_dly
      logic [LATENCY-1:0] vld_q;
      logic [ENT_W-1:0]   ent_q [LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < LATENCY; i++) ent_q[i] <= '0;
        end else begin
          vld_q[0] <= req_fire;
          if (req_fire) ent_q[0] <= in_ent;
          for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            ent_q[i] <= ent_q[i-1];
          end
        end
      end

      assign push_vld = vld_q[LATENCY-1];
      assign push_ent = ent_q[LATENCY-1];
    end
  endgenerate

  ibus_rsp_fifo #(
    .DEPTH (OUTST),
    .WIDTH (ENT_W)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_vld),
    .pop   (rsp_fire),
    .din   (push_ent),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rsp_data_o = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
  assign rsp_err_o  = ~fifo_empty & fifo_dout[DATA_W];

endmodule

// File: tb/tb_ibus_mem_responder.sv
// tb/tb_ibus_mem_responder.sv - scoreboard testbench for ibus_mem_responder
module tb_ibus_mem_responder;

  localparam int          MEM_DEPTH = 1024;
  localparam int          LAT       = 2;
  localparam int          OUTST     = 2;
  localparam logic [31:0] NOP       = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        ld_wr_en_i = 1'b0;
  logic [31:0] ld_addr_i = '0;
  logic [31:0] ld_data_i = '0;

  always #5 clk = ~clk;

  ibus_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(MEM_DEPTH), .LATENCY(LAT), .OUTST(OUTST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .ld_wr_en_i(ld_wr_en_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [MEM_DEPTH];
  int          cyc = 0;
  int          outst = 0;
  int          last_pop = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a);
    logic err;
    err = (a >> 2) >= MEM_DEPTH;
`ifdef IBUS_ALIGN_CHK_EN
    err = err | (a[1:0] != 2'b00);
`endif
    return err ? {1'b1, NOP} : {1'b0, ref_mem[a[11:2]]};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: samples mid-cycle, so handshake values are the ones the next edge will see.
  initial forever begin
    exp_t        h;
    int          exp_c;
    logic [32:0] e;
    @(negedge clk);
    if (!rst_n) begin
      chk("reset rsp_valid", {31'b0, rsp_valid_o}, 0);
      chk("reset req_ready", {31'b0, req_ready_o}, 0);
      chk("reset rsp_data", rsp_data_o, 0);
      chk("reset rsp_err", {31'b0, rsp_err_o}, 0);
      exp_q.delete();
      outst    = 0;
      last_pop = 0;
    end else begin
      chk("req_ready credit", {31'b0, req_ready_o}, {31'b0, outst < OUTST});
      if (exp_q.size() == 0) begin
        chk("no stale rsp_valid", {31'b0, rsp_valid_o}, 0);
      end else begin
        h = exp_q[0];
        exp_c = (h.cyc + LAT + 1 > last_pop + 1) ? h.cyc + LAT + 1 : last_pop + 1;
        chk("rsp_valid timing", {31'b0, rsp_valid_o}, {31'b0, cyc >= exp_c});
        if (rsp_valid_o) begin
          chk("rsp_data", rsp_data_o, h.data);
          chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, h.err});
        end
      end
      if (rsp_valid_o && rsp_ready_i && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        last_pop = cyc;
        outst--;
      end
      if (req_valid_i && req_ready_o) begin
        e = model(req_addr_i);
        exp_q.push_back('{data: e[31:0], err: e[32], cyc: cyc});
        outst++;
      end
      if (ld_wr_en_i && ((ld_addr_i >> 2) < MEM_DEPTH)) ref_mem[ld_addr_i[11:2]] = ld_data_i;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int w, input logic [31:0] d);
    ld_wr_en_i = 1'b1;
    ld_addr_i  = w * 4;
    ld_data_i  = d;
    tick();
    ld_wr_en_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] a);
    int n;
    n = 0;
    req_valid_i = 1'b1;
    req_addr_i  = a;
    while (!req_ready_o && n < 50) begin
      tick();
      n++;
    end
    chk("request accepted", {31'b0, req_ready_o}, 1);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready_i = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    chk("drain queue empty", exp_q.size(), 0);
  endtask

  initial begin
    int r;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    load(0, 32'h00500093);
    load(1, 32'h00100113);
    for (int i = 2; i < 64; i++) load(i, $urandom);

    rsp_ready_i = 1'b1;
    send(32'h0);
    drain();
    send(32'h0); send(32'h4); send(32'h8); send(32'hC);
    drain();

    // Backpressure: two requests fill the credits, the third waits.
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = 32'h0; tick();
    req_addr_i  = 32'h4; tick();
    req_addr_i  = 32'h8;
    repeat (4) tick();
    chk("ready low at OUTST", {31'b0, req_ready_o}, 0);
    rsp_ready_i = 1'b1;
    send(32'h8);
    drain();

    send(32'h1000); send(32'h2); send(32'hFFFF_FFFC); send(32'h4);
    drain();

    // Loader write and fetch of the same word in one cycle.
    ld_wr_en_i  = 1'b1; ld_addr_i = 32'h8; ld_data_i = 32'hDEADBEEF;
    req_valid_i = 1'b1; req_addr_i = 32'h8;
    tick();
    ld_wr_en_i  = 1'b0; req_valid_i = 1'b0;
    send(32'h8);
    drain();

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 7);
      req_valid_i = ($urandom_range(0, 3) != 0);
      if (r == 0) req_addr_i = 32'h1000 + ($urandom_range(0, 255) << 2);
      else        req_addr_i = ($urandom_range(0, 63) << 2) | ((r == 1) ? $urandom_range(1, 3) : 0);
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      ld_wr_en_i  = ($urandom_range(0, 7) == 0);
      ld_addr_i   = ($urandom_range(0, 9) == 0) ? 32'h2000 : ($urandom_range(0, 63) << 2);
      ld_data_i   = $urandom;
      tick();
    end
    req_valid_i = 1'b0;
    ld_wr_en_i  = 1'b0;
    drain();

    // Reset with two requests in flight: nothing may come out afterwards.
    rsp_ready_i = 1'b0;
    send(32'h0); send(32'h4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rsp_ready_i = 1'b1;
    repeat (10) tick();
    send(32'h10);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
